axi_rd_responder: RTL and testbench
===================================

// Module: axi_rd_responder
// PURPOSE
//  AXI4 read-channel responder (slave) backed by an internal 64-bit word memory. Accepts one AR
//  request at a time, returns FIXED/INCR/WRAP bursts on R. Serves as the memory/bus model that
//  answers the core's instruction-fetch read master in simulation and integration benches.
//  Backdoor write port preloads program images.
// PARAMETERS
//  ID_WIDTH    13    width of arid/rid
//  ADDR_WIDTH  64    byte address width
//  DATA_WIDTH  64    data width; only 64 supported (one word = 8 bytes)
//  MEM_WORDS   4096  words in backing array; word index = addr[ADDR_WIDTH-1:3]
//  RD_LATENCY  2     idle cycles between AR handshake and first rvalid (0..15)
// PORTS
//  clk            in   1           clock, all logic on posedge
//  reset          in   1           synchronous, active-high
//  s_axi_arid     in   ID_WIDTH    request id
//  s_axi_araddr   in   ADDR_WIDTH  start byte address
//  s_axi_arlen    in   8           beats-1
//  s_axi_arsize   in   3           log2 bytes/beat; only 3 legal
//  s_axi_arburst  in   2           0 FIXED, 1 INCR, 2 WRAP, 3 reserved
//  s_axi_arvalid  in   1           request valid
//  s_axi_arready  out  1           request accepted when arvalid&&arready
//  s_axi_rid      out  ID_WIDTH    echo of captured arid
//  s_axi_rdata    out  DATA_WIDTH  beat data
//  s_axi_rresp    out  2           00 OKAY, 10 SLVERR, 11 DECERR
//  s_axi_rlast    out  1           final beat of burst
//  s_axi_rvalid   out  1           beat valid
//  s_axi_rready   in   1           beat accepted when rvalid&&rready
//  mem_we         in   1           backdoor write strobe
//  mem_waddr      in   ADDR_WIDTH  backdoor byte address (bits [2:0] ignored)
//  mem_wdata      in   DATA_WIDTH  backdoor write data
// BEHAVIOUR
//  Reset: arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, state=IDLE; memory contents kept.
//  FSM IDLE -> WAIT -> BEAT -> IDLE.
//   IDLE: arready=1 (from first cycle after reset deasserts). On AR handshake capture id, addr,
//    len, size, burst; load latency counter=RD_LATENCY; go WAIT (arready=0 next cycle).
//   WAIT: count down; at 0 fetch beat 0, assert rvalid next cycle -> first rvalid at T+1+RD_LATENCY
//    (T = AR handshake cycle). RD_LATENCY=0 skips WAIT.
//   BEAT: rvalid held, rid/rdata/rresp/rlast stable until rready. On handshake of non-last beat,
//    next beat presented the following cycle (rvalid stays 1, back-to-back, 1 beat/cycle).
//    On handshake with rlast: rvalid=0 next cycle, go IDLE; arready=1 that same next cycle.
//  Only one outstanding request; arready=0 outside IDLE.
//  Address generation (word index w, beat n):
//   FIXED: w constant. INCR: w+1 per beat, full ADDR_WIDTH wrap, no 4KB check.
//   WRAP: len in {1,3,7,15} only; wrap span = (len+1) words; w = base | ((w+1)&(len)),
//    base = start & ~len. Start word need not be aligned (critical-word-first).
//  Errors (per burst, still returns exactly len+1 beats with rdata=0 and rlast on last):
//   arsize!=3, arburst==3, or WRAP with illegal len -> rresp=10 all beats.
//  Per beat: word index >= MEM_WORDS -> rresp=11, rdata=0; other beats unaffected.
//  Read data sampled from array when beat is fetched (registered); held stable while stalled.
//  Backdoor write same cycle as fetch of same word: fetched data is the OLD value.
//  Backdoor writes out of range ignored; backdoor accepted in every state.
//  reset mid-burst: next cycle all outputs at reset values, burst discarded, no rlast issued.
// STRUCTURE
//  axi_pkg: burst enum (FIXED/INCR/WRAP), resp constants (OKAY/SLVERR/DECERR), state enum.
//  Sub-module axi_burst_addr_gen: combinational next-word-index from (cur, start, len, burst).
//  Top: FSM, latency/beat counters, capture regs, memory array, R output regs.
// TESTING
//  1 WRAP araddr=0x28 len=7 size=3 -> 8 beats words 5,6,7,0,1,2,3,4; rid echoed; rlast beat 8.
//  2 INCR araddr=0x100 len=3, rready low 3 cycles on beat 1 -> rdata/rlast stable, no beat lost.
//  3 AR at cycle T, RD_LATENCY=2 -> first rvalid at T+3; arready=1 cycle after last handshake.
//  4 arsize=2 len=1 -> 2 beats rresp=10 rdata=0; araddr=MEM_WORDS*8-8 INCR len=1 -> 00 then 11.
//  5 reset asserted mid WRAP beat 3 -> rvalid=0, arready=0 next cycle; new AR served correctly.
//  6 backdoor write word 5 same cycle beat fetch of word 5 -> old data; next FIXED read -> new.

Source files
------------

// File: rtl/axi_rd_responder_pkg.sv
// Shared types and constants for the AXI4 read responder.
package axi_rd_responder_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Only 8-byte beats are served; anything else is a slave error.
  localparam logic [2:0] SIZE_DWORD  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT
  } state_t;

  // WRAP bursts must span a power-of-two number of beats (2, 4, 8 or 16).
  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Whole-burst error: every beat of such a burst returns SLVERR with zero data.
  function automatic logic burst_illegal(input logic [2:0] size, input burst_t burst,
                                         input logic [7:0] len);
    return (size != SIZE_DWORD) || (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !wrap_len_legal(len));
  endfunction

endpackage

// File: rtl/axi_rd_responder_burst_addr_gen.sv
// Next word index for a read burst. Purely combinational; the caller
// registers the result as the current beat's word.
module axi_burst_addr_gen
  import axi_rd_responder_pkg::*;
#(
  parameter int AW = 61
) (
  input  logic [AW-1:0] cur,
  input  logic [AW-1:0] start,
  input  logic [7:0]    len,
  input  burst_t        burst,
  output logic [AW-1:0] nxt
);

  logic [AW-1:0] mask;
  logic [AW-1:0] base;
  logic [AW-1:0] inc;

  assign mask = AW'(len);
  // Wrap window is aligned to the span; start itself may sit mid-window.
  assign base = start & ~mask;
  assign inc  = cur + AW'(1);

  // FIXED repeats the word, INCR walks the whole address space, WRAP folds
  // back inside the aligned window. Reserved bursts never reach the data path.
  always_comb begin
    nxt = cur;
    case (burst)
      BURST_INCR: nxt = inc;
      BURST_WRAP: nxt = base | (inc & mask);
      default:    nxt = cur;
    endcase
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder backed by a 64-bit word memory with a
// backdoor write port for program preload. One request outstanding at a time.
module axi_rd_responder
  import axi_rd_responder_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 4096,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam int AW       = ADDR_WIDTH - 3;
  localparam int IW       = $clog2(MEM_WORDS);
  localparam int LAT_W    = 4;
  // Counter holds remaining idle cycles minus one; fetch happens when it reaches zero.
  localparam int LAT_INIT = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

  state_t                state;
  logic [LAT_W-1:0]      lat_cnt;
  logic [7:0]            beats_left;
  logic [ID_WIDTH-1:0]   cap_id;
  logic [AW-1:0]         start_w;
  logic [AW-1:0]         cur_w;
  logic [7:0]            cap_len;
  burst_t                cap_burst;
  logic                  cap_err;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  ar_hs;
  logic                  ar_err;
  burst_t                ar_burst;
  logic [AW-1:0]         ar_w;
  logic [AW-1:0]         next_w;
  logic [AW-1:0]         fetch_w;
  logic                  fetch_bad;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic [1:0]            fetch_resp;
  logic [AW-1:0]         wr_w;
  logic                  unused_lo;

  assign ar_hs    = s_axi_arvalid && s_axi_arready;
  assign ar_burst = burst_t'(s_axi_arburst);
  assign ar_err   = burst_illegal(s_axi_arsize, ar_burst, s_axi_arlen);
  assign ar_w     = s_axi_araddr[ADDR_WIDTH-1:3];
  assign wr_w     = mem_waddr[ADDR_WIDTH-1:3];
  // Byte offsets within a word carry no meaning for 8-byte beats.
  assign unused_lo = ^{s_axi_araddr[2:0], mem_waddr[2:0]};

  axi_burst_addr_gen #(.AW(AW)) u_addr_gen (
    .cur   (cur_w),
    .start (start_w),
    .len   (cap_len),
    .burst (cap_burst),
    .nxt   (next_w)
  );

  // Pick the word being fetched this cycle and form its data/response.
  // IDLE fetches straight from the AR bus (zero-latency case), WAIT fetches
  // beat 0 from the capture regs, BEAT fetches the following word.
  always_comb begin
    fetch_w   = cur_w;
    fetch_bad = cap_err;
    if (state == ST_IDLE) begin
      fetch_w   = ar_w;
      fetch_bad = ar_err;
    end else if (state == ST_BEAT) begin
      fetch_w   = next_w;
    end
    fetch_data = '0;
    fetch_resp = RESP_OKAY;
    if (fetch_bad)
      fetch_resp = RESP_SLVERR;
    else if (fetch_w >= AW'(MEM_WORDS))
      fetch_resp = RESP_DECERR;
    else
      fetch_data = mem[fetch_w[IW-1:0]];
  end

  // Backdoor preload; independent of the FSM and of reset. A fetch of the
  // same word on the same edge sees the old contents.
  always_ff @(posedge clk) begin
    if (mem_we && (wr_w < AW'(MEM_WORDS)))
      mem[wr_w[IW-1:0]] <= mem_wdata;
  end

  // Request/response FSM with registered R-channel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      lat_cnt       <= '0;
      beats_left    <= '0;
      cap_id        <= '0;
      start_w       <= '0;
      cur_w         <= '0;
      cap_len       <= '0;
      cap_burst     <= BURST_FIXED;
      cap_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            cap_id        <= s_axi_arid;
            start_w       <= ar_w;
            cur_w         <= ar_w;
            cap_len       <= s_axi_arlen;
            cap_burst     <= ar_burst;
            cap_err       <= ar_err;
            if (RD_LATENCY == 0) begin
              s_axi_rvalid <= 1'b1;
              s_axi_rid    <= s_axi_arid;
              s_axi_rdata  <= fetch_data;
              s_axi_rresp  <= fetch_resp;
              s_axi_rlast  <= (s_axi_arlen == 8'd0);
              beats_left   <= s_axi_arlen;
              state        <= ST_BEAT;
            end else begin
              lat_cnt      <= LAT_W'(LAT_INIT);
              state        <= ST_WAIT;
            end
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rid    <= cap_id;
            s_axi_rdata  <= fetch_data;
            s_axi_rresp  <= fetch_resp;
            s_axi_rlast  <= (cap_len == 8'd0);
            beats_left   <= cap_len;
            state        <= ST_BEAT;
          end else begin
            lat_cnt      <= lat_cnt - LAT_W'(1);
          end
        end
        ST_BEAT: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              cur_w         <= next_w;
              s_axi_rdata   <= fetch_data;
              s_axi_rresp   <= fetch_resp;
              s_axi_rlast   <= (beats_left == 8'd1);
              beats_left    <= beats_left - 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Scoreboard bench for axi_rd_responder: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted R beat.
module tb_axi_rd_responder;

  localparam int ID_W  = 13;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int WORDS = 4096;
  localparam int LAT   = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   data;
    logic [1:0]      resp;
    logic            last;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [ID_W-1:0] arid = '0;
  logic [AW-1:0]   araddr = '0;
  logic [7:0]      arlen = '0;
  logic [2:0]      arsize = 3'd3;
  logic [1:0]      arburst = 2'd1;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready = 1'b0;
  logic            mem_we = 1'b0;
  logic [AW-1:0]   mem_waddr = '0;
  logic [DW-1:0]   mem_wdata = '0;

  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    t_ar = 0;
  int    ar_count = 0;
  int    beats_seen = 0;
  int    rr_mode = 0;   // 0: rready high, 1: random, 2: held low
  beat_t exp_q[$];
  logic [DW-1:0] model_mem [WORDS];

  axi_rd_responder #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_WORDS(WORDS), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: beat list from the burst rules with plain arithmetic.
  task automatic push_burst(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    longint unsigned w0, w, span, base;
    logic  bad;
    beat_t b;
    w0   = longint'(addr >> 3);
    span = longint'(len) + 1;
    bad  = (size != 3'd3) || (burst == 2'd3) ||
           (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    for (int n = 0; n <= int'(len); n++) begin
      if (burst == 2'd1)      w = w0 + longint'(n);
      else if (burst == 2'd2) begin
        base = (w0 / span) * span;
        w    = base + ((w0 - base + longint'(n)) % span);
      end else                w = w0;
      b.id   = id;
      b.last = (n == int'(len));
      if (bad) begin
        b.data = '0; b.resp = 2'b10;
      end else if (w >= longint'(WORDS)) begin
        b.data = '0; b.resp = 2'b11;
      end else begin
        b.data = model_mem[w]; b.resp = 2'b00;
      end
      exp_q.push_back(b);
    end
  endtask

  // Call at #1 after a posedge; returns at #1 after the AR handshake edge.
  task automatic send_ar(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int k;
    push_burst(id, addr, len, size, burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (arready) break;
      k++;
    end
    if (k >= 2000) chk("arready_timeout", {127'd0, arready}, 128'd1);
    t_ar = cyc + 1;
    ar_count++;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rvalid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic bd_write(input int w, input logic [DW-1:0] d);
    mem_we = 1'b1; mem_waddr = AW'(w) << 3; mem_wdata = d;
    if (w < WORDS) model_mem[w] = d;
    @(posedge clk); #1;
    mem_we = 1'b0;
  endtask

  // rready driver
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0:       rready = 1'b1;
      1:       rready = ($urandom % 3) != 0;
      default: rready = 1'b0;
    endcase
  end

  // Monitor: stall stability, first-beat latency, arready reopening, scoreboard.
  initial begin : mon
    logic [80:0] cur, prev;
    logic stall, last_hs;
    int ar_seen;
    beat_t a, e;
    stall = 1'b0; last_hs = 1'b0; ar_seen = 0; prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0; last_hs = 1'b0; ar_seen = ar_count;
      end else begin
        cur = {rvalid, rid, rdata, rresp, rlast};
        if (stall) chk("stall_hold", 128'(cur), 128'(prev));
        if (last_hs) chk("arready_after_last", {127'd0, arready}, 128'd1);
        last_hs = 1'b0;
        if (rvalid && ar_seen != ar_count) begin
          chk("first_rvalid_cycle", 128'(cyc + 1), 128'(t_ar + 1 + LAT));
          ar_seen = ar_count;
        end
        if (rvalid && rready) begin
          a = '{id: rid, data: rdata, resp: rresp, last: rlast};
          if (exp_q.size() == 0) chk("beat_unexpected", 128'(a), 128'd0);
          else begin
            e = exp_q.pop_front();
            chk("beat", 128'(a), 128'(e));
          end
          last_hs = rlast;
          beats_seen++;
        end
        stall = rvalid && !rready;
        prev  = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [DW-1:0] old5, new5, w0v;
    int b0, k, sel, wsel;
    logic [7:0] len;
    logic [1:0] bt;
    logic [2:0] sz;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 128'({arready, rvalid, rlast, rresp, rid, rdata}), 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 256; i++) bd_write(i, {$urandom, $urandom});
    for (int i = WORDS - 16; i < WORDS; i++) bd_write(i, {$urandom, $urandom});

    // WRAP critical-word-first
    send_ar(13'h0a5, 64'h28, 8'd7, 3'd3, 2'd2);
    drain();

    // INCR with a 3-cycle stall on the first beat
    rr_mode = 2;
    send_ar(13'h111, 64'h100, 8'd3, 3'd3, 2'd1);
    k = 0;
    while (!rvalid && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rr_mode = 0;
    drain();

    // Whole-burst size error, then INCR crossing the end of memory
    send_ar(13'h002, 64'h40, 8'd1, 3'd2, 2'd1);
    drain();
    send_ar(13'h003, 64'(WORDS * 8 - 8), 8'd1, 3'd3, 2'd1);
    drain();

    // Out-of-range backdoor write must not alias word 0
    w0v = model_mem[0];
    bd_write(WORDS, ~w0v);
    send_ar(13'h004, 64'h0, 8'd0, 3'd3, 2'd0);
    drain();

    // Backdoor write on the same edge as the fetch of word 5
    old5 = model_mem[5];
    new5 = ~old5 ^ 64'h5555;
    send_ar(13'h005, 64'h28, 8'd0, 3'd3, 2'd0);
    repeat (LAT - 1) begin @(posedge clk); #1; end
    mem_we = 1'b1; mem_waddr = 64'h28; mem_wdata = new5;
    model_mem[5] = new5;
    @(posedge clk); #1;
    mem_we = 1'b0;
    drain();
    send_ar(13'h006, 64'h2c, 8'd2, 3'd3, 2'd0);
    drain();

    // Randomized bursts with random back-pressure
    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom % 16;
      bt  = (sel < 5) ? 2'd1 : (sel < 10) ? 2'd2 : (sel < 15) ? 2'd0 : 2'd3;
      sz  = (($urandom % 10) == 0) ? 3'd2 : 3'd3;
      if (bt == 2'd2) begin
        case ($urandom % 5)
          0: len = 8'd1; 1: len = 8'd3; 2: len = 8'd7; 3: len = 8'd15;
          default: len = 8'd2;
        endcase
      end else len = 8'($urandom % 16);
      wsel = (($urandom % 4) == 0) ? (WORDS - 8 + int'($urandom % 8)) : int'($urandom % 200);
      send_ar(13'($urandom), (64'(wsel) << 3) | 64'($urandom % 8), len, sz, bt);
      if ((i % 5) == 4) begin
        drain();
        bd_write(int'($urandom % 200), {$urandom, $urandom});
      end
    end
    rr_mode = 0;
    drain();

    // Reset in the middle of a WRAP burst
    send_ar(13'h0bb, 64'h48, 8'd7, 3'd3, 2'd2);
    b0 = beats_seen;
    k = 0;
    while (beats_seen < b0 + 3 && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    reset = 1'b1; rr_mode = 2;
    @(posedge clk);
    @(negedge clk);
    chk("mid_burst_reset", 128'({arready, rvalid, rlast, rresp, rid, rdata}), 128'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0; rr_mode = 0;
    send_ar(13'h0cc, 64'h38, 8'd3, 3'd3, 2'd2);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
